sobel3x3_edge: RTL and testbench
================================

SOBEL3X3_EDGE -- requirements
Module: sobel3x3_edge

Interface
REQ-001 Parameter IMAGE_WIDTH, default 320, pixels per row of the incoming smoothed stream.
REQ-002 Parameter IMAGE_HEIGHT, default 240, rows per frame; the row counter wraps at this value.
REQ-003 Parameter EDGE_THRESH, default 128, binarisation threshold used only when SOBEL_THRESH_EN is defined.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 gauss_valid  input  1  qualifies gauss_out for one cycle; may deassert for any number of cycles.
REQ-007 gauss_out  input  8  smoothed grey pixel, raster order.
REQ-008 sobel_valid  output  1  one-cycle pulse qualifying sobel_mag and the centre coordinates.
REQ-009 sobel_mag  output  8  saturated gradient magnitude, or binary 0/255 when thresholding is enabled.
REQ-010 center_row  output  16  row index of the window centre for the current output.
REQ-011 center_col  output  16  column index of the window centre for the current output.

Function
REQ-012 The block SHALL hold two line buffers of IMAGE_WIDTH x 8 bits, addressed by a column counter, plus a 3x3 window register set.
REQ-013 On each accepted pixel (gauss_valid=1), the block SHALL shift the window left one column, load the new column from {linebuf1[col], linebuf0[col], gauss_out} (top to bottom), write linebuf1[col]<=linebuf0[col] and linebuf0[col]<=gauss_out.
REQ-014 The column counter SHALL increment per accepted pixel and wrap from IMAGE_WIDTH-1 to 0; on wrap the row counter SHALL increment, wrapping from IMAGE_HEIGHT-1 to 0.
REQ-015 Gx = (p02+2*p12+p22) - (p00+2*p10+p20) and Gy = (p20+2*p21+p22) - (p00+2*p01+p02), each in signed 11-bit arithmetic with no overflow.
REQ-016 Magnitude = |Gx|+|Gy| (12-bit unsigned); sobel_mag SHALL be 255 when the magnitude exceeds 255, else its low 8 bits.
REQ-017 Pipeline: cycle 0 accept/window update, cycle 1 register Gx/Gy, cycle 2 register sobel_mag/sobel_valid; latency exactly 2 clocks from the accepting edge to the output edge, irrespective of gauss_valid gaps.
REQ-018 sobel_valid SHALL be 1 only for pixels accepted at row>=2 and col>=2; window contents at other positions are don't-care and SHALL NOT produce valid.
REQ-019 center_row = accepted row-1, center_col = accepted col-1, delayed to align with sobel_valid.
REQ-020 When sobel_valid=0, sobel_mag and the centre coordinates SHALL hold their previous values.
REQ-021 Exactly (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2) valid pulses SHALL be produced per frame.

Reset
REQ-022 With rst=1 on a clock edge: sobel_valid=0, sobel_mag=0, center_row=0, center_col=0, column/row counters=0, window and pipeline registers=0.
REQ-023 Line buffer contents need not be cleared; the REQ-018 masking covers stale data.
REQ-024 Reset asserted mid-frame SHALL discard all in-flight pipeline results (no sobel_valid in the 2 cycles after reset releases); the next accepted pixel is treated as row 0, col 0.

Configuration
REQ-025 Macro SOBEL_THRESH_EN: if defined, sobel_mag = 255 when the saturated magnitude >= EDGE_THRESH, else 0; latency unchanged.
REQ-026 Without SOBEL_THRESH_EN, sobel_mag is the saturated magnitude of REQ-016 and EDGE_THRESH is unused.

Verification
REQ-027 Constant frame of value 100, 320x240, gauss_valid held high -> every output sobel_mag=0, 75684 sobel_valid pulses.
REQ-028 Vertical step (col<160 -> 0, else 255) -> sobel_mag=255 (saturated from 1020) at center_col 159 and 160, 0 elsewhere.
REQ-029 Horizontal ramp pixel=col -> sobel_mag=8 at every valid output; first valid at center_row=1, center_col=1, 2 clocks after accepting row 2 col 2.
REQ-030 Same ramp with gauss_valid toggling 1/0 each cycle -> identical output values and count; each sobel_valid exactly 2 clocks after its accepting edge.
REQ-031 SOBEL_THRESH_EN defined, EDGE_THRESH=128, step image of REQ-028 -> outputs only 0 or 255, 255 at center_col 159/160.
REQ-032 rst pulsed at row 5 col 100 -> sobel_valid=0 until new row 2 col 2 accepted; center_row restarts at 1.

Source files
------------

// File: rtl/sobel3x3_edge_if.sv
// Pixel-stream interface for sobel3x3_edge.
// The master drives the smoothed input pixel stream; the slave (the edge
// detector) returns the gradient magnitude with its window-centre coordinates.
interface sobel3x3_edge_if;
    logic        gauss_valid;
    logic [7:0]  gauss_out;
    logic        sobel_valid;
    logic [7:0]  sobel_mag;
    logic [15:0] center_row;
    logic [15:0] center_col;

    modport master (
        output gauss_valid,
        output gauss_out,
        input  sobel_valid,
        input  sobel_mag,
        input  center_row,
        input  center_col
    );

    modport slave (
        input  gauss_valid,
        input  gauss_out,
        output sobel_valid,
        output sobel_mag,
        output center_row,
        output center_col
    );
endinterface

// File: rtl/sobel3x3_edge.sv
// 3x3 Sobel edge detector on a raster-order 8-bit grey stream.
// Two line buffers feed a 3x3 window; |Gx|+|Gy| is saturated to 8 bits and
// emitted two clocks after the accepting edge, only for windows fully inside
// the frame (accepted row>=2 and col>=2).
// Optional build macro: SOBEL_THRESH_EN -- binarise the output to 0/255
// against EDGE_THRESH (saturated magnitude >= EDGE_THRESH gives 255).
module sobel3x3_edge #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int EDGE_THRESH  = 128
) (
    input  logic          clk,
    input  logic          rst,
    sobel3x3_edge_if.slave bus
);

    localparam int          AW       = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [15:0] COL_LAST = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(IMAGE_HEIGHT - 1);

    // (pos taps) - (neg taps) with the middle tap doubled, signed 11-bit
    function automatic logic signed [10:0] f_grad(
        input logic [7:0] a_pos, input logic [7:0] b_pos, input logic [7:0] c_pos,
        input logic [7:0] a_neg, input logic [7:0] b_neg, input logic [7:0] c_neg
    );
        logic signed [10:0] s_pos;
        logic signed [10:0] s_neg;
        s_pos = $signed({3'b000, a_pos}) + ($signed({3'b000, b_pos}) <<< 1)
              + $signed({3'b000, c_pos});
        s_neg = $signed({3'b000, a_neg}) + ($signed({3'b000, b_neg}) <<< 1)
              + $signed({3'b000, c_neg});
        return s_pos - s_neg;
    endfunction

    function automatic logic [11:0] f_abs(input logic signed [10:0] v);
        logic [10:0] m;
        m = (v < 0) ? 11'(-v) : 11'(v);
        return {1'b0, m};
    endfunction

    function automatic logic [7:0] f_sat(input logic [11:0] m);
        return (m > 12'd255) ? 8'd255 : m[7:0];
    endfunction

    function automatic logic [7:0] f_post(input logic [7:0] s);
`ifdef SOBEL_THRESH_EN
        return ($signed({24'd0, s}) >= EDGE_THRESH) ? 8'd255 : 8'd0;
`else
        return s;
`endif
    endfunction

    logic [7:0]  r_lb0 [IMAGE_WIDTH];
    logic [7:0]  r_lb1 [IMAGE_WIDTH];
    logic [7:0]  r_win [3][3];
    logic [15:0] r_col;
    logic [15:0] r_row;

    logic        r_vld_p0;
    logic [15:0] r_crow_p0;
    logic [15:0] r_ccol_p0;

    logic signed [10:0] r_gx_p1;
    logic signed [10:0] r_gy_p1;
    logic        r_vld_p1;
    logic [15:0] r_crow_p1;
    logic [15:0] r_ccol_p1;

    logic        r_vld_p2;
    logic [7:0]  r_mag_p2;
    logic [15:0] r_crow_p2;
    logic [15:0] r_ccol_p2;

    logic          w_accept;
    logic [AW-1:0] w_idx;
    logic [7:0]    w_lb0_rd;
    logic [7:0]    w_lb1_rd;
    logic signed [10:0] w_gx;
    logic signed [10:0] w_gy;
    logic [11:0]   w_mag;

    assign w_accept = bus.gauss_valid;
    assign w_idx    = r_col[AW-1:0];
    assign w_lb0_rd = r_lb0[w_idx];
    assign w_lb1_rd = r_lb1[w_idx];

    // Line buffers: push the current column down one row; contents never reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_idx] <= w_lb0_rd;
            r_lb0[w_idx] <= bus.gauss_out;
        end
    end

    // Stage 0: accept pixel, shift window, advance raster counters, tag validity
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_vld_p0  <= 1'b0;
            r_crow_p0 <= '0;
            r_ccol_p0 <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            r_vld_p0 <= w_accept && (r_row >= 16'd2) && (r_col >= 16'd2);
            if (w_accept) begin
                r_crow_p0 <= r_row - 16'd1;
                r_ccol_p0 <= r_col - 16'd1;
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb1_rd;
                r_win[1][2] <= w_lb0_rd;
                r_win[2][2] <= bus.gauss_out;
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? 16'd0 : r_row + 16'd1;
                end else begin
                    r_col <= r_col + 16'd1;
                end
            end
        end
    end

    assign w_gx = f_grad(r_win[0][2], r_win[1][2], r_win[2][2],
                         r_win[0][0], r_win[1][0], r_win[2][0]);
    assign w_gy = f_grad(r_win[2][0], r_win[2][1], r_win[2][2],
                         r_win[0][0], r_win[0][1], r_win[0][2]);

    // Stage 1: register Gx/Gy with the valid flag and centre coordinates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gx_p1   <= '0;
            r_gy_p1   <= '0;
            r_vld_p1  <= 1'b0;
            r_crow_p1 <= '0;
            r_ccol_p1 <= '0;
        end else begin
            r_gx_p1   <= w_gx;
            r_gy_p1   <= w_gy;
            r_vld_p1  <= r_vld_p0;
            r_crow_p1 <= r_crow_p0;
            r_ccol_p1 <= r_ccol_p0;
        end
    end

    assign w_mag = f_abs(r_gx_p1) + f_abs(r_gy_p1);

    // Stage 2: saturate/binarise; outputs hold between valid pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_mag_p2  <= '0;
            r_crow_p2 <= '0;
            r_ccol_p2 <= '0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_mag_p2  <= f_post(f_sat(w_mag));
                r_crow_p2 <= r_crow_p1;
                r_ccol_p2 <= r_ccol_p1;
            end
        end
    end

    assign bus.sobel_valid = r_vld_p2;
    assign bus.sobel_mag   = r_mag_p2;
    assign bus.center_row  = r_crow_p2;
    assign bus.center_col  = r_ccol_p2;

endmodule

// File: tb/tb_sobel3x3_edge.sv
// Directed bench for sobel3x3_edge on a reduced 8x6 frame.
// Each table row describes one frame (step image or linear ramp) with its
// hand-computed interior magnitude; a monitor matches every output pulse to
// the pixel that produced it (value, centre, and 2-clock latency).
module tb_sobel3x3_edge;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int THR = 128;
    localparam int NPF = (W - 2) * (H - 2);

    typedef struct {
        int step;      // 1: left half 0, right half 255
        int gap;       // 1: gauss_valid toggles 1/0
        int base;      // ramp: pixel = base + a*col + b*row
        int a;
        int b;
        int exp_mag;   // saturated magnitude away from the step edge
        int edge_mag;  // saturated magnitude at centre cols W/2-1 and W/2
    } vec_t;

    typedef struct {
        int mag;
        int crow;
        int ccol;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    sobel3x3_edge_if bus ();

    sobel3x3_edge #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .EDGE_THRESH  (THR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    vec_t tbl[12];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   nvalid = 0;
    int   last_mag = 0;
    int   last_crow = 0;
    int   last_ccol = 0;
    bit   chk_en = 1'b0;

    function automatic int f_exp(input int m);
`ifdef SOBEL_THRESH_EN
        return (m >= THR) ? 255 : 0;
`else
        return m;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_frame(input vec_t v, input int stop_r, input int stop_c);
        int   px;
        exp_t e;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                px = (v.step != 0) ? ((c < W / 2) ? 0 : 255) : v.base + v.a * c + v.b * r;
                @(negedge clk);
                bus.gauss_valid = 1'b1;
                bus.gauss_out   = 8'(px);
                if (r >= 2 && c >= 2) begin
                    e.mag  = f_exp(((v.step != 0) && (c - 1 == W / 2 - 1 || c - 1 == W / 2))
                                   ? v.edge_mag : v.exp_mag);
                    e.crow = r - 1;
                    e.ccol = c - 1;
                    e.due  = cyc + 3;
                    q.push_back(e);
                end
                if (v.gap != 0) begin
                    @(negedge clk);
                    bus.gauss_valid = 1'b0;
                    bus.gauss_out   = 8'hA5;
                end
            end
        end
        @(negedge clk);
        bus.gauss_valid = 1'b0;
    endtask

    task automatic drain_check(input string name, input int exp_cnt);
        repeat (5) @(negedge clk);
        #1;
        chk({name, "_count"}, nvalid, exp_cnt);
        chk({name, "_pending"}, q.size(), 0);
        nvalid = 0;
    endtask

    // Clock-edge counter used to time-stamp expected outputs
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Output monitor: every pulse must match the oldest outstanding pixel
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                while (q.size() > 0 && q[0].due < cyc) begin
                    m = q.pop_front();
                    chk("missing_valid", 0, 1);
                end
                if (bus.sobel_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        m = q.pop_front();
                        chk("latency_cycle", cyc, m.due);
                        chk("mag", int'(bus.sobel_mag), m.mag);
                        chk("center_row", int'(bus.center_row), m.crow);
                        chk("center_col", int'(bus.center_col), m.ccol);
                        last_mag  = m.mag;
                        last_crow = m.crow;
                        last_ccol = m.ccol;
                        nvalid++;
                    end
                end else begin
                    chk("hold_mag", int'(bus.sobel_mag), last_mag);
                    chk("hold_row", int'(bus.center_row), last_crow);
                    chk("hold_col", int'(bus.center_col), last_ccol);
                end
            end
        end
    end

    initial begin
        //           step gap base   a    b  mag edge
        tbl[0]  = '{0, 0, 100,   0,   0,   0,   0};  // flat frame
        tbl[1]  = '{1, 0,   0,   0,   0,   0, 255};  // vertical step, 1020 -> 255
        tbl[2]  = '{0, 0,   0,   1,   0,   8,   8};  // horizontal ramp
        tbl[3]  = '{0, 1,   0,   1,   0,   8,   8};  // same ramp, valid toggling
        tbl[4]  = '{0, 0,   0,   0,  10,  80,  80};  // vertical ramp (Gy only)
        tbl[5]  = '{0, 0, 255, -10,   0,  80,  80};  // negative Gx
        tbl[6]  = '{0, 0,   0,  16,  16, 255, 255};  // 256 saturates
        tbl[7]  = '{0, 0,   0,  16,  15, 248, 248};  // just below saturation
        tbl[8]  = '{0, 1,   0,   8,   8, 128, 128};  // threshold boundary, gapped
        tbl[9]  = '{0, 0,   0,   8,   7, 120, 120};  // just below threshold
        tbl[10] = '{0, 0, 250,   0, -10,  80,  80};  // negative Gy
        tbl[11] = '{0, 0, 100,   6,  -6,  96,  96};  // mixed signs

        rst = 1'b1;
        bus.gauss_valid = 1'b0;
        bus.gauss_out   = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_valid", int'(bus.sobel_valid), 0);
        chk("reset_mag", int'(bus.sobel_mag), 0);
        chk("reset_row", int'(bus.center_row), 0);
        chk("reset_col", int'(bus.center_col), 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive_frame(tbl[i], -1, -1);
            drain_check($sformatf("frame%0d", i), NPF);
        end

        // Two frames back to back: row counter wraps with results in flight
        drive_frame(tbl[4], -1, -1);
        drive_frame(tbl[1], -1, -1);
        drain_check("back_to_back", 2 * NPF);

        // Reset mid-frame with pixels in flight and gauss_valid held high
        drive_frame(tbl[2], 3, 5);
        @(negedge clk);
        rst = 1'b1;
        bus.gauss_valid = 1'b1;
        bus.gauss_out   = 8'd77;
        #1;
        q.delete();
        last_mag  = 0;
        last_crow = 0;
        last_ccol = 0;
        nvalid    = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.gauss_valid = 1'b0;
        drive_frame(tbl[2], -1, -1);
        drain_check("after_reset", NPF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
